// File: rtl/result_drain_if.sv
// Handshake bundle for result_drain: frame capture on the in_* side, beat drain on the out_* side.
interface result_drain_if #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64
);
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  // master drives frames in and accepts beats out; slave is the drain block itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/result_drain.sv
// Two-entry ping-pong frame buffer that serialises wide result frames into OUT_WIDTH beats.
module result_drain #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  result_drain_if.slave bus,
  output logic          frame_done,
  output logic [1:0]    occupancy
);

  localparam int BEATS  = IN_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 2) begin : g_bad_params
      $error("result_drain: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end
  endgenerate

  logic [IN_WIDTH-1:0]  mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [BEAT_W-1:0]    beat_idx;
  logic [BEAT_W-1:0]    slice_idx;
  logic [IN_WIDTH-1:0]  head;
  logic [OUT_WIDTH-1:0] head_beats [BEATS];
  logic                 push;
  logic                 beat_hs;
  logic                 pop;

  // in_ready and out_valid come from registered state only, so out_ready never reaches in_ready
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0) && !flush;
  assign bus.out_last  = bus.out_valid && (beat_idx == LAST_BEAT);

  assign push    = bus.in_valid && bus.in_ready && !flush;
  assign beat_hs = bus.out_valid && bus.out_ready;
  assign pop     = beat_hs && bus.out_last;

  assign head      = mem[rd_ptr];
  assign slice_idx = LSB_FIRST ? beat_idx : (LAST_BEAT - beat_idx);

  for (genvar b = 0; b < BEATS; b++) begin : g_slice
    assign head_beats[b] = head[b*OUT_WIDTH +: OUT_WIDTH];
  end

  assign bus.out_data = bus.out_valid ? head_beats[slice_idx] : '0;
  assign occupancy    = count;

  // NOTE: frame storage has no reset; only control state decides what is valid, and a
  // resettable 2 x IN_WIDTH array would just cost reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every update in this block
  // sees the pre-edge values of count/pointers, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      beat_idx   <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      beat_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (beat_hs) begin
        beat_idx <= bus.out_last ? '0 : beat_idx + 1'b1;
      end
      // a capture coinciding with a last-beat pop leaves the count unchanged
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; monitors check beats and frame_done.
module tb_result_drain;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [511:0] in_data;
  logic         out_ready;
  logic         frame_done0, frame_done1;
  logic [1:0]   occupancy0, occupancy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t q0[$];
  beat_t q1[$];
  int    hs_cnt0 = 0;
  int    last_hs0 = 0;
  int    fd_cnt0 = 0;
  logic  prev_last0 = 1'b0;
  logic  prev_last1 = 1'b0;

  result_drain_if #(.IN_WIDTH(512), .OUT_WIDTH(64)) bus0 ();
  result_drain_if #(.IN_WIDTH(512), .OUT_WIDTH(64)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  result_drain #(.IN_WIDTH(512), .OUT_WIDTH(64), .LSB_FIRST(1'b1)) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .bus        (bus0),
    .frame_done (frame_done0),
    .occupancy  (occupancy0)
  );

  result_drain #(.IN_WIDTH(512), .OUT_WIDTH(64), .LSB_FIRST(1'b0)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .bus        (bus1),
    .frame_done (frame_done1),
    .occupancy  (occupancy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // frame word i holds base+i, so LSB-first beat k is base+k and MSB-first beat k is base+7-k
  function automatic logic [511:0] make_frame(input logic [63:0] base);
    logic [511:0] f;
    for (int i = 0; i < 8; i++) f[i*64 +: 64] = base + 64'(i);
    return f;
  endfunction

  task automatic push_expected(input logic [63:0] base);
    for (int k = 0; k < 8; k++) begin
      q0.push_back('{data: base + 64'(k),     last: (k == 7)});
      q1.push_back('{data: base + 64'(7 - k), last: (k == 7)});
    end
  endtask

  task automatic send(input logic [63:0] base, output int cap_cyc, output int waited);
    bit done;
    done    = 1'b0;
    waited  = 0;
    cap_cyc = -1;
    in_data  = make_frame(base);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        push_expected(base);
        @(posedge clk);
        #1;
        cap_cyc = cyc;
        done    = 1'b1;
      end else begin
        waited++;
      end
    end
    in_valid = 1'b0;
    if (!done) check("send timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 100 && !empty; i++) begin
      @(posedge clk);
      #1;
      empty = (q0.size() == 0) && (q1.size() == 0);
    end
    if (!empty) check("drain timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_last0 = 1'b0;
    end else begin
      check("frame_done0", 64'(frame_done0), 64'(prev_last0));
      if (frame_done0) fd_cnt0++;
      prev_last0 = 1'b0;
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) begin
          check("unexpected beat0", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = q0.pop_front();
          check("beat0 data", bus0.out_data, e.data);
          check("beat0 last", 64'(bus0.out_last), 64'(e.last));
        end
        prev_last0 = bus0.out_last;
        hs_cnt0++;
        last_hs0 = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_last1 = 1'b0;
    end else begin
      check("frame_done1", 64'(frame_done1), 64'(prev_last1));
      prev_last1 = 1'b0;
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) begin
          check("unexpected beat1", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = q1.pop_front();
          check("beat1 data", bus1.out_data, e.data);
          check("beat1 last", 64'(bus1.out_last), 64'(e.last));
        end
        prev_last1 = bus1.out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, w, hs_base, fd_base;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready",   64'(bus0.in_ready),  64'd1);
    check("rst out_valid",  64'(bus0.out_valid), 64'd0);
    check("rst out_last",   64'(bus0.out_last),  64'd0);
    check("rst out_data",   bus0.out_data,       64'd0);
    check("rst occupancy",  64'(occupancy0),     64'd0);
    check("rst frame_done", 64'(frame_done0),    64'd0);
    check("rst occupancy1", 64'(occupancy1),     64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle in_ready",  64'(bus0.in_ready),  64'd1);
    check("idle out_valid", 64'(bus0.out_valid), 64'd0);
    check("idle occupancy", 64'(occupancy0),     64'd0);

    // single frame, free-flowing output
    out_ready = 1'b1;
    fd_base   = fd_cnt0;
    send(64'h0, c1, w);
    check("latency out_valid", 64'(bus0.out_valid), 64'd1);
    check("first beat lsb",    bus0.out_data,       64'h0);
    check("first beat msb",    bus1.out_data,       64'h7);
    wait_drain();
    check("single occupancy",  64'(occupancy0),     64'd0);
    check("single fd count",   64'(fd_cnt0 - fd_base), 64'd1);

    // backpressure at beat 3
    send(64'h0, c1, w);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", 64'(bus0.out_valid), 64'd1);
      check("bp data lsb",  bus0.out_data,       64'h3);
      check("bp data msb",  bus1.out_data,       64'h4);
      check("bp last",      64'(bus0.out_last),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // back-to-back frames with in_valid held
    hs_base = hs_cnt0;
    fd_base = fd_cnt0;
    send(64'h20, c1, w);
    send(64'h30, c2, w);
    check("b2b occupancy full", 64'(occupancy0),    64'd2);
    check("b2b in_ready full",  64'(bus0.in_ready), 64'd0);
    send(64'h40, c3, w);
    check("b2b third waited",   64'(w > 0),         64'd1);
    check("b2b third capture",  64'(c3 - c1),       64'd9);
    wait_drain();
    check("b2b beat count",     64'(hs_cnt0 - hs_base), 64'd24);
    check("b2b no gap",         64'(last_hs0 - c1),     64'd24);
    check("b2b fd count",       64'(fd_cnt0 - fd_base), 64'd3);

    // flush after beat 4 with two frames held
    out_ready = 1'b0;
    send(64'h50, c1, w);
    send(64'h60, c2, w);
    check("fl occupancy full", 64'(occupancy0), 64'd2);
    out_ready = 1'b1;
    fd_base   = fd_cnt0;
    repeat (5) @(posedge clk);
    #1;
    check("fl mid data", bus0.out_data, 64'h55);
    flush = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl out_valid",  64'(bus0.out_valid), 64'd0);
    check("fl occupancy",  64'(occupancy0),     64'd0);
    check("fl in_ready",   64'(bus0.in_ready),  64'd1);
    check("fl frame_done", 64'(frame_done0),    64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("fl no fd", 64'(fd_cnt0 - fd_base), 64'd0);

    // reset pulse mid-frame, then a clean frame from empty
    out_ready = 1'b0;
    send(64'h70, c1, w);
    send(64'h80, c2, w);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("rm out_valid",  64'(bus0.out_valid), 64'd0);
    check("rm occupancy",  64'(occupancy0),     64'd0);
    check("rm in_ready",   64'(bus0.in_ready),  64'd1);
    check("rm frame_done", 64'(frame_done0),    64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    fd_base = fd_cnt0;
    send(64'h90, c1, w);
    check("rm latency", 64'(bus0.out_valid), 64'd1);
    check("rm beat0",   bus0.out_data,       64'h90);
    wait_drain();
    check("rm fd count",  64'(fd_cnt0 - fd_base), 64'd1);
    check("rm occupancy end", 64'(occupancy0),     64'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
